// File: rtl/keypad_pkg.sv
// Shared types and tables for the 4x4 keypad scanner: FSM states,
// column drive patterns and the row/column to hex key map.
package keypad_pkg;

  localparam int unsigned KP_W = 4;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  localparam logic [KP_W-1:0] ROWS_IDLE = 4'b1111;

  // Active-low column drive, indexed by column number.
  localparam logic [KP_W-1:0] COL_ONEHOT [4] = '{
    4'b1110, 4'b1101, 4'b1011, 4'b0111
  };

  // Indexed by {row, col}; row 3 carries '*' as E and '#' as F.
  localparam logic [KP_W-1:0] KEY_MAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

  function automatic logic [1:0] lowest_low_row(input logic [KP_W-1:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic logic [KP_W-1:0] key_lookup(input logic [1:0] row,
                                                 input logic [1:0] col);
    return KEY_MAP[{row, col}];
  endfunction

endpackage

// File: rtl/module_sync2.sv
// Two-flop synchronizer bringing the asynchronous keypad rows into clk.
module module_sync2 #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/module_keypad_scan.sv
// 4x4 matrix keypad scanner: rotates the column drive, debounces press and
// release on the frozen column and reports the accepted key as a hex code.
module module_keypad_scan
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 27000,
  parameter int unsigned DEBOUNCE_CNT = 270000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [KP_W-1:0] row_i,
  output logic [KP_W-1:0] col_o,
  output logic [KP_W-1:0] key_code,
  output logic            key_valid,
  output logic            key_held
);

  localparam int unsigned MAX_PARAM = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
  localparam int unsigned CNT_W     = $clog2(MAX_PARAM) + 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [KP_W-1:0] rows_s;

  state_e          state_q,   state_d;
  logic [1:0]      col_idx_q, col_idx_d;
  logic [KP_W-1:0] col_q,     col_d;
  logic [CNT_W-1:0] div_q,    div_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [KP_W-1:0] pat_q,     pat_d;
  logic [1:0]      row_idx_q, row_idx_d;
  logic [KP_W-1:0] code_q,    code_d;
  logic            valid_q,   valid_d;
  logic            held_q,    held_d;

  module_sync2 #(
    .WIDTH (KP_W)
  ) u_row_sync (
    .clk (clk),
    .rst (rst),
    .d_i (row_i),
    .q_o (rows_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= SCAN;
      col_idx_q <= 2'd0;
      col_q     <= COL_ONEHOT[0];
      div_q     <= '0;
      cnt_q     <= '0;
      pat_q     <= ROWS_IDLE;
      row_idx_q <= 2'd0;
      code_q    <= '0;
      valid_q   <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_idx_q <= col_idx_d;
      col_q     <= col_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      pat_q     <= pat_d;
      row_idx_q <= row_idx_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      held_q    <= held_d;
    end
  end

  // Next-state: scan, lock on a low row, then debounce press and release.
  always_comb begin
    state_d   = state_q;
    col_idx_d = col_idx_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    pat_d     = pat_q;
    row_idx_d = row_idx_q;
    code_d    = code_q;
    valid_d   = 1'b0;
    held_d    = held_q;

    case (state_q)
      SCAN: begin
        // Rows are only trusted on the slot's last cycle, after the synchronizer settles.
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (rows_s != ROWS_IDLE) begin
            pat_d     = rows_s;
            row_idx_d = lowest_low_row(rows_s);
            cnt_d     = '0;
            state_d   = DEBOUNCE;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end else begin
          div_d = div_q + CNT_W'(1);
        end
      end

      DEBOUNCE: begin
        if (rows_s == pat_q) begin
          if (cnt_q == DEB_LAST) begin
            code_d  = key_lookup(row_idx_q, col_idx_q);
            valid_d = 1'b1;
            held_d  = 1'b1;
            cnt_d   = '0;
            state_d = PRESSED;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d     = '0;
          div_d     = '0;
          col_idx_d = col_idx_q + 2'd1;
          state_d   = SCAN;
        end
      end

      PRESSED: begin
        if (rows_s == ROWS_IDLE) begin
          cnt_d   = '0;
          state_d = RELEASE;
        end
      end

      RELEASE: begin
        if (rows_s == ROWS_IDLE) begin
          if (cnt_q == DEB_LAST) begin
            held_d    = 1'b0;
            cnt_d     = '0;
            div_d     = '0;
            col_idx_d = col_idx_q + 2'd1;
            state_d   = SCAN;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d   = '0;
          state_d = PRESSED;
        end
      end

      default: begin
        state_d = SCAN;
      end
    endcase

    col_d = COL_ONEHOT[col_idx_d];
  end

  assign col_o     = col_q;
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;

endmodule

// File: tb/tb_module_keypad_scan.sv
// Bench for module_keypad_scan: a keypad model drives the rows from the
// column drive and a cycle-level behavioural reference checks every output.
module tb_module_keypad_scan;

  localparam int SD = 4;
  localparam int DC = 8;

  localparam int HEXMAP [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};
  localparam logic [3:0] EXP_SEQ [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD
  };

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] row_i;
  logic [3:0] col_o;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] keys;
  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;
  bit prev_valid;
  int dut_pulses = 0;
  logic [3:0] code_log [$];

  // Reference model state
  logic [3:0] sh1, sh2;
  int   m_t, m_base, m_run, m_lcol;
  bit   m_locked, m_held, m_rel, m_valid;
  logic [3:0] m_pat, m_code;

  always #5 clk = ~clk;

  module_keypad_scan #(
    .SCAN_DIV     (SD),
    .DEBOUNCE_CNT (DC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .row_i     (row_i),
    .col_o     (col_o),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  // Physical keypad: a pressed key pulls its row low while its column is driven.
  always_comb begin
    row_i = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_o[c]) row_i[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int low_row(input logic [3:0] rows);
    for (int r = 0; r < 4; r++) if (!rows[r]) return r;
    return 0;
  endfunction

  function automatic int model_col();
    if (m_locked) return m_lcol;
    return (m_base + m_t / SD) % 4;
  endfunction

  function automatic logic [3:0] model_col_drive();
    logic [3:0] v;
    v = 4'b0001 << model_col();
    return ~v;
  endfunction

  task automatic model_reset();
    sh1 = 4'h0; sh2 = 4'h0;
    m_t = 0; m_base = 0; m_run = 0; m_lcol = 0;
    m_locked = 1'b0; m_held = 1'b0; m_rel = 1'b0; m_valid = 1'b0;
    m_pat = 4'hF; m_code = 4'h0;
  endtask

  task automatic model_resume();
    m_locked = 1'b0;
    m_base   = (m_lcol + 1) % 4;
    m_t      = 0;
    m_run    = 0;
  endtask

  task automatic model_step();
    logic [3:0] rows;
    int col;
    rows = sh2;
    sh2  = sh1;
    sh1  = row_i;
    m_valid = 1'b0;
    col = model_col();
    if (!m_locked) begin
      if ((m_t % SD) == SD - 1 && rows != 4'hF) begin
        m_locked = 1'b1; m_lcol = col; m_pat = rows; m_run = 0;
      end else begin
        m_t++;
      end
    end else if (!m_held) begin
      if (rows == m_pat) begin
        m_run++;
        if (m_run == DC) begin
          m_code  = 4'(HEXMAP[low_row(m_pat)*4 + m_lcol]);
          m_valid = 1'b1;
          m_held  = 1'b1;
          m_rel   = 1'b0;
          m_run   = 0;
        end
      end else begin
        model_resume();
      end
    end else if (!m_rel) begin
      if (rows == 4'hF) begin m_rel = 1'b1; m_run = 0; end
    end else if (rows == 4'hF) begin
      m_run++;
      if (m_run == DC) begin m_held = 1'b0; model_resume(); end
    end else begin
      m_rel = 1'b0;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  // Every-cycle comparison of the DUT against the reference model.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else if (chk_en) begin
      check("col_o",     32'(col_o),     32'(model_col_drive()));
      check("key_code",  32'(key_code),  32'(m_code));
      check("key_valid", 32'(key_valid), 32'(m_valid));
      check("key_held",  32'(key_held),  32'(m_held));
      check("valid_twice", 32'(key_valid & prev_valid), 32'd0);
      if (key_valid) begin
        dut_pulses++;
        code_log.push_back(key_code);
      end
      prev_valid = key_valid;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int p0;
    int guard;
    int kind;
    int a, b;
    keys = '0;
    rst  = 1'b1;
    cycles(3);
    check("rst_col",   32'(col_o),     32'h0000_000E);
    check("rst_code",  32'(key_code),  32'd0);
    check("rst_valid", 32'(key_valid), 32'd0);
    check("rst_held",  32'(key_held),  32'd0);
    rst    = 1'b0;
    chk_en = 1'b1;
    cycles(4);
    check("rot_col1", 32'(col_o), 32'h0000_000D);
    cycles(4);
    check("rot_col2", 32'(col_o), 32'h0000_000B);
    cycles(4);
    check("rot_col3", 32'(col_o), 32'h0000_0007);
    cycles(4);
    check("rot_col0", 32'(col_o), 32'h0000_000E);

    // Key '5' held 40 cycles, then released.
    p0 = dut_pulses;
    keys[5] = 1'b1;
    cycles(40);
    check("k5_pulses", 32'(dut_pulses - p0), 32'd1);
    check("k5_code",   32'(key_code), 32'h5);
    check("k5_held",   32'(key_held), 32'd1);
    check("k5_model_code", 32'(m_code), 32'h5);
    keys = '0;
    cycles(12);
    check("k5_release", 32'(key_held), 32'd0);
    check("k5_code_kept", 32'(key_code), 32'h5);
    cycles(10);

    // Key '9' bouncing every 3 cycles, then stable.
    p0 = dut_pulses;
    for (int i = 0; i < 10; i++) begin
      keys[10] = ~keys[10];
      cycles(3);
    end
    keys[10] = 1'b1;
    cycles(40);
    check("k9_pulses", 32'(dut_pulses - p0), 32'd1);
    check("k9_code",   32'(key_code), 32'h9);
    keys = '0;
    cycles(20);

    // Every key in turn.
    p0 = dut_pulses;
    code_log.delete();
    for (int k = 0; k < 16; k++) begin
      keys = 16'(1) << k;
      cycles(40);
      keys = '0;
      cycles(20);
    end
    check("all_pulses", 32'(dut_pulses - p0), 32'd16);
    for (int i = 0; i < 16; i++) begin
      if (i < code_log.size()) check("all_seq", 32'(code_log[i]), 32'(EXP_SEQ[i]));
    end

    // '3' held, 'C' pressed meanwhile: no rollover.
    p0 = dut_pulses;
    keys[2] = 1'b1;
    cycles(35);
    keys[11] = 1'b1;
    cycles(20);
    check("roll_code", 32'(key_code), 32'h3);
    keys[11] = 1'b0;
    cycles(3);
    keys[2] = 1'b0;
    cycles(20);
    check("roll_pulses", 32'(dut_pulses - p0), 32'd1);
    check("roll_held",   32'(key_held), 32'd0);

    // Reset in the middle of debouncing '7'.
    p0 = dut_pulses;
    keys[8] = 1'b1;
    guard = 0;
    while (!(m_locked && !m_held) && guard < 60) begin
      cycles(1);
      guard++;
    end
    check("k7_lock_seen", 32'(guard < 60), 32'd1);
    cycles(3);
    rst = 1'b1;
    cycles(2);
    check("k7_rst_code",  32'(key_code),  32'd0);
    check("k7_rst_valid", 32'(key_valid), 32'd0);
    rst = 1'b0;
    check("k7_no_pulse", 32'(dut_pulses - p0), 32'd0);
    cycles(40);
    check("k7_pulses", 32'(dut_pulses - p0), 32'd1);
    check("k7_code",   32'(key_code), 32'h7);
    keys = '0;
    cycles(20);

    // Random presses, taps, chords, bounces and occasional resets.
    for (int it = 0; it < 80; it++) begin
      kind = int'($urandom_range(0, 9));
      a = int'($urandom_range(0, 15));
      b = int'($urandom_range(0, 15));
      if (kind <= 3) begin
        keys[a] = 1'b1;
        cycles(int'($urandom_range(1, 45)));
      end else if (kind <= 5) begin
        keys[a] = 1'b1;
        keys[b] = 1'b1;
        cycles(int'($urandom_range(5, 45)));
      end else if (kind <= 7) begin
        for (int j = 0; j < 6; j++) begin
          keys[a] = ~keys[a];
          cycles(int'($urandom_range(1, 9)));
        end
      end else if (kind == 8) begin
        keys[a] = 1'b1;
        cycles(int'($urandom_range(1, 10)));
      end else begin
        keys[a] = 1'b1;
        cycles(int'($urandom_range(5, 30)));
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        cycles(int'($urandom_range(1, 30)));
      end
      keys = '0;
      cycles(int'($urandom_range(1, 30)));
    end
    cycles(30);
    check("end_held", 32'(key_held), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/module_keypad_scan.md
MODULE_KEYPAD_SCAN -- requirements
Module: module_keypad_scan

Interface
REQ-001 Parameter SCAN_DIV, default 27000, clk cycles each column stays driven (minimum 2).
REQ-002 Parameter DEBOUNCE_CNT, default 270000, consecutive stable cycles required to accept a press or a release (minimum 2).
REQ-003 Port clk  input  1  system clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port row_i  input  4  keypad rows, active-low, asynchronous to clk, external pull-ups.
REQ-006 Port col_o  output  4  keypad columns, active-low, exactly one bit low at any time.
REQ-007 Port key_code  output  4  hex code of the last accepted key; drives the LED stage directly.
REQ-008 Port key_valid  output  1  one-cycle pulse when key_code is updated.
REQ-009 Port key_held  output  1  high from acceptance of a press until acceptance of its release.

Function
REQ-010 row_i SHALL pass through a 2-flop synchronizer; all logic SHALL use only the synchronized value (rows_s).
REQ-011 The FSM SHALL have the states SCAN, DEBOUNCE, PRESSED and RELEASE.
REQ-012 In SCAN, col_o SHALL rotate 1110 -> 1101 -> 1011 -> 0111 -> 1110, advancing every SCAN_DIV cycles.
REQ-013 In SCAN, on the last cycle of a column slot, rows_s != 1111 SHALL latch the column index and the lowest-index low row, and the FSM SHALL go to DEBOUNCE.
REQ-014 In every state except SCAN, col_o SHALL be frozen on the latched column.
REQ-015 DEBOUNCE: the counter SHALL increment while rows_s equals the latched pattern; any mismatch SHALL return the FSM to SCAN with no output change.
REQ-016 After DEBOUNCE_CNT consecutive matching cycles, the FSM SHALL update key_code, pulse key_valid for one cycle, set key_held, and go to PRESSED.
REQ-017 Key map (row,col): r0 = 1,2,3,A; r1 = 4,5,6,B; r2 = 7,8,9,C; r3 = E(*),0,F(#),D.
REQ-018 PRESSED: the FSM SHALL stay while rows_s != 1111; rows_s == 1111 SHALL move it to RELEASE with the counter cleared.
REQ-019 RELEASE: the counter SHALL count cycles with rows_s == 1111; any low row SHALL return the FSM to PRESSED; at DEBOUNCE_CNT the FSM SHALL clear key_held and go to SCAN, resuming at the next column.
REQ-020 A second key pressed while in PRESSED or RELEASE SHALL be ignored (no rollover); key_code SHALL hold its value between presses.
REQ-021 key_valid SHALL never be high on two consecutive cycles.
REQ-022 Counters SHALL saturate and never wrap in DEBOUNCE or RELEASE; the scan divider SHALL wrap to 0 at SCAN_DIV-1.
REQ-023 Counter widths SHALL be $clog2 of the larger parameter plus 1.

Reset
REQ-024 Asserting rst SHALL immediately force state = SCAN, col_o = 1110, key_code = 0000, key_valid = 0, key_held = 0, and clear all counters and synchronizer flops.
REQ-025 Reset asserted in the middle of DEBOUNCE or PRESSED SHALL discard the press; after release, a still-held key SHALL be re-detected through a full debounce.

Structure
REQ-026 Package keypad_pkg SHALL hold the state enum, the 16-entry key map table, and the column one-hot constants.
REQ-027 Sub-module module_sync2 (2-flop synchronizer, 4 bits wide) SHALL be used; all other logic SHALL be in a single module.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=8; behavioral keypad model drives row_i from col_o)
REQ-028 Reset: rst high -> col_o=1110, key_code=0000, key_valid=0, key_held=0; after release, col_o rotates every 4 cycles.
REQ-029 Press key '5' (r1,c1), held 40 cycles -> single key_valid pulse, key_code=0101, key_held=1; after release + 8 cycles -> key_held=0.
REQ-030 Bounce: '9' toggled every 3 cycles for 30 cycles, then held stable -> exactly one key_valid, key_code=1001.
REQ-031 All 16 keys pressed in turn -> key_code sequence 1,2,3,A,4,5,6,B,7,8,9,C,E,0,F,D with 16 pulses.
REQ-032 '3' held and 'C' pressed during PRESSED -> key_code stays 0011, no extra pulse.
REQ-033 rst pulsed during DEBOUNCE of '7' -> no key_valid; key still held -> key_code=0111 after a fresh debounce.
